// File: rtl/ahb_lite_arbiter_if.sv
// Bus bundle for the two-master AHB-Lite arbiter: per-master request/response
// signals plus the shared system-side address, data and response signals.
interface ahb_lite_arbiter_if;
    logic [1:0]  HTRANS_M1, HTRANS_M2;
    logic        HWRITE_M1, HWRITE_M2;
    logic [2:0]  HSIZE_M1,  HSIZE_M2;
    logic [2:0]  HBURST_M1, HBURST_M2;
    logic [31:0] HADDR_M1,  HADDR_M2;
    logic [31:0] HWDATA_M1, HWDATA_M2;
    logic [3:0]  HPROT_M1,  HPROT_M2;
    logic        HREADY_M1, HREADY_M2;
    logic [31:0] HRDATA_M1, HRDATA_M2;
    logic [1:0]  HRESP_M1,  HRESP_M2;

    logic        HREADY;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HADDR;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;

    // master: the arbiter, which drives the shared bus on behalf of both cores
    modport master (
        input  HTRANS_M1, HTRANS_M2, HWRITE_M1, HWRITE_M2, HSIZE_M1, HSIZE_M2,
               HBURST_M1, HBURST_M2, HADDR_M1, HADDR_M2, HWDATA_M1, HWDATA_M2,
               HPROT_M1, HPROT_M2, HREADY, HRDATA, HRESP,
        output HREADY_M1, HREADY_M2, HRDATA_M1, HRDATA_M2, HRESP_M1, HRESP_M2,
               HTRANS, HWRITE, HSIZE, HBURST, HADDR, HPROT, HWDATA
    );

    // slave: the surroundings (requesting masters and the addressed slave)
    modport slave (
        output HTRANS_M1, HTRANS_M2, HWRITE_M1, HWRITE_M2, HSIZE_M1, HSIZE_M2,
               HBURST_M1, HBURST_M2, HADDR_M1, HADDR_M2, HWDATA_M1, HWDATA_M2,
               HPROT_M1, HPROT_M2, HREADY, HRDATA, HRESP,
        input  HREADY_M1, HREADY_M2, HRDATA_M1, HRDATA_M2, HRESP_M1, HRESP_M2,
               HTRANS, HWRITE, HSIZE, HBURST, HADDR, HPROT, HWDATA
    );
endinterface

// File: rtl/ahb_lite_arbiter.sv
// Two-master AHB-Lite arbiter: registered grant with burst lock, debugger (M2)
// priority bounded by a core starvation limit, and data-phase response capture.
module ahb_lite_arbiter #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    ahb_lite_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX   = SW'(STARVE_LIMIT);
    localparam logic [1:0]    TR_IDLE      = 2'b00;
    localparam logic [1:0]    TR_NONSEQ    = 2'b10;
    localparam logic [1:0]    TR_SEQ       = 2'b11;
    localparam logic [2:0]    BURST_SINGLE = 3'b000;

    typedef enum logic {OWN_M1 = 1'b0, OWN_M2 = 1'b1} owner_t;

    owner_t        a_own_reg, a_own_next;
    owner_t        d_own_reg, d_own_next;
    logic          d_act_reg, d_act_next;
    logic [1:0]    pend_reg, pend_next;
    logic [31:0]   hold_data_reg, hold_data_next;
    logic [1:0]    hold_resp_reg, hold_resp_next;
    logic [SW-1:0] streak_reg, streak_next, streak_upd;

    logic [1:0]    trans [2];
    logic [1:0]    req;
    logic [1:0]    ready;
    logic [1:0]    cap;
    logic [31:0]   rdata [2];
    logic [1:0]    resp  [2];
    logic [1:0]    own_trans;
    logic [2:0]    own_burst;
    logic          own_req;
    logic          locked;

    assign trans[0] = bus.HTRANS_M1;
    assign trans[1] = bus.HTRANS_M2;

    assign own_trans = (a_own_reg == OWN_M2) ? bus.HTRANS_M2 : bus.HTRANS_M1;
    assign own_burst = (a_own_reg == OWN_M2) ? bus.HBURST_M2 : bus.HBURST_M1;
    assign own_req   = own_trans[1];
    assign locked    = (own_trans == TR_SEQ) ||
                       ((own_trans == TR_NONSEQ) && (own_burst != BURST_SINGLE));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mst
            localparam owner_t ME = (gi == 1) ? OWN_M2 : OWN_M1;
            logic is_a;
            logic is_d;
            logic idle;

            assign req[gi] = trans[gi][1];
            assign is_a    = (a_own_reg == ME);
            assign is_d    = (d_own_reg == ME) && d_act_reg;
            assign idle    = (trans[gi] == TR_IDLE);

            // A master that lost the address phase must not take HREADY as
            // acceptance of the address it is still holding; its data-phase
            // result is parked instead and replayed when it is regranted.
            assign ready[gi] = is_a      ? bus.HREADY :
                               is_d      ? (idle & bus.HREADY) :
                               pend_reg[gi] ? 1'b0 : idle;
            assign cap[gi]   = !is_a && is_d && !idle && bus.HREADY;
            assign rdata[gi] = pend_reg[gi] ? hold_data_reg : bus.HRDATA;
            assign resp[gi]  = pend_reg[gi] ? hold_resp_reg :
                               is_d         ? bus.HRESP     : 2'b00;
        end
    endgenerate

    // Count includes the M2 transfer being accepted this cycle, so the grant
    // flips to M1 right after the STARVE_LIMIT-th consecutive M2 transfer.
    always_comb begin
        streak_upd = streak_reg;
        if (!req[0] || (a_own_reg == OWN_M1)) begin
            streak_upd = '0;
        end else if (req[1] && (streak_reg != STREAK_MAX)) begin
            streak_upd = streak_reg + SW'(1);
        end
    end

    always_comb begin
        a_own_next     = a_own_reg;
        d_own_next     = d_own_reg;
        d_act_next     = d_act_reg;
        pend_next      = pend_reg;
        hold_data_next = hold_data_reg;
        hold_resp_next = hold_resp_reg;
        streak_next    = streak_reg;
        if (bus.HREADY) begin
            d_own_next  = a_own_reg;
            d_act_next  = own_req;
            streak_next = streak_upd;
            if (!locked) begin
                if (req[1] && (!req[0] || (streak_upd < STREAK_MAX))) begin
                    a_own_next = OWN_M2;
                end else if (req[0]) begin
                    a_own_next = OWN_M1;
                end
            end
            if (a_own_reg == OWN_M1) begin
                pend_next[0] = 1'b0;
            end else begin
                pend_next[1] = 1'b0;
            end
            if ((cap != 2'b00) && (pend_reg == 2'b00)) begin
                pend_next      = pend_next | cap;
                hold_data_next = bus.HRDATA;
                hold_resp_next = bus.HRESP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_own_reg     <= OWN_M1;
            d_own_reg     <= OWN_M1;
            d_act_reg     <= 1'b0;
            pend_reg      <= 2'b00;
            hold_data_reg <= '0;
            hold_resp_reg <= 2'b00;
            streak_reg    <= '0;
        end else begin
            a_own_reg     <= a_own_next;
            d_own_reg     <= d_own_next;
            d_act_reg     <= d_act_next;
            pend_reg      <= pend_next;
            hold_data_reg <= hold_data_next;
            hold_resp_reg <= hold_resp_next;
            streak_reg    <= streak_next;
        end
    end

    assign bus.HTRANS    = (a_own_reg == OWN_M2) ? bus.HTRANS_M2 : bus.HTRANS_M1;
    assign bus.HWRITE    = (a_own_reg == OWN_M2) ? bus.HWRITE_M2 : bus.HWRITE_M1;
    assign bus.HSIZE     = (a_own_reg == OWN_M2) ? bus.HSIZE_M2  : bus.HSIZE_M1;
    assign bus.HBURST    = own_burst;
    assign bus.HADDR     = (a_own_reg == OWN_M2) ? bus.HADDR_M2  : bus.HADDR_M1;
    assign bus.HPROT     = (a_own_reg == OWN_M2) ? bus.HPROT_M2  : bus.HPROT_M1;
    assign bus.HWDATA    = (d_own_reg == OWN_M2) ? bus.HWDATA_M2 : bus.HWDATA_M1;

    assign bus.HREADY_M1 = ready[0];
    assign bus.HREADY_M2 = ready[1];
    assign bus.HRDATA_M1 = rdata[0];
    assign bus.HRDATA_M2 = rdata[1];
    assign bus.HRESP_M1  = resp[0];
    assign bus.HRESP_M2  = resp[1];
endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed bench for ahb_lite_arbiter: reset, single read, contention, burst
// lock, response capture, starvation limit, async reset and ERROR response.
module tb_ahb_lite_arbiter;
    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

    ahb_lite_arbiter_if bus ();

    ahb_lite_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-20s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic m1(input logic [1:0] t, input logic [2:0] b, input logic [31:0] a);
        bus.HTRANS_M1 = t;
        bus.HBURST_M1 = b;
        bus.HADDR_M1  = a;
    endtask

    task automatic m2(input logic [1:0] t, input logic [2:0] b, input logic [31:0] a);
        bus.HTRANS_M2 = t;
        bus.HBURST_M2 = b;
        bus.HADDR_M2  = a;
    endtask

    initial begin
        rst = 1'b1;
        m1(IDLE, SINGLE, 32'h0);
        m2(IDLE, SINGLE, 32'h0);
        bus.HWRITE_M1 = 1'b0; bus.HWRITE_M2 = 1'b0;
        bus.HSIZE_M1  = 3'd2; bus.HSIZE_M2  = 3'd2;
        bus.HPROT_M1  = 4'h3; bus.HPROT_M2  = 4'h3;
        bus.HWDATA_M1 = 32'hAAAA_0001;
        bus.HWDATA_M2 = 32'h5555_0002;
        bus.HREADY    = 1'b1;
        bus.HRDATA    = 32'h0;
        bus.HRESP     = 2'b00;
        #1;
        chk("rst_hready_m2", 32'(bus.HREADY_M2), 1);
        chk("rst_hready_m1", 32'(bus.HREADY_M1), 1);
        chk("rst_htrans", 32'(bus.HTRANS), 0);
        chk("rst_hwdata", bus.HWDATA, 32'hAAAA_0001);
        chk("rst_a_own", 32'(dut.a_own_reg), 0);
        cyc(); rst = 1'b0;

        // M1 single read
        cyc(); m1(NONSEQ, SINGLE, 32'h0000_1000); #1;
        chk("rd_htrans", 32'(bus.HTRANS), 2);
        chk("rd_haddr", bus.HADDR, 32'h0000_1000);
        chk("rd_hready_m1", 32'(bus.HREADY_M1), 1);
        cyc(); m1(IDLE, SINGLE, 32'h0); bus.HRDATA = 32'hDEAD_BEEF; #1;
        chk("rd_hrdata_m1", bus.HRDATA_M1, 32'hDEAD_BEEF);
        chk("rd_hready_m1_d", 32'(bus.HREADY_M1), 1);

        // M2 single write to move ownership to M2
        cyc(); m2(NONSEQ, SINGLE, 32'h0000_2000); #1;
        chk("m2req_hready_m2", 32'(bus.HREADY_M2), 0);
        chk("m2req_htrans", 32'(bus.HTRANS), 0);
        cyc(); #1;
        chk("m2wr_haddr", bus.HADDR, 32'h0000_2000);
        chk("m2wr_hready_m2", 32'(bus.HREADY_M2), 1);
        chk("m2wr_hwdata_m1", bus.HWDATA, 32'hAAAA_0001);
        cyc(); m2(IDLE, SINGLE, 32'h0); #1;
        chk("m2wr_hwdata_m2", bus.HWDATA, 32'h5555_0002);

        // Contention: both request together
        cyc(); m1(NONSEQ, SINGLE, 32'h0000_3000); m2(NONSEQ, SINGLE, 32'h0000_4000); #1;
        chk("cont_haddr_m2", bus.HADDR, 32'h0000_4000);
        chk("cont_hready_m2", 32'(bus.HREADY_M2), 1);
        chk("cont_hready_m1", 32'(bus.HREADY_M1), 0);
        cyc(); m2(IDLE, SINGLE, 32'h0); bus.HRDATA = 32'h0000_4444; #1;
        chk("cont_hrdata_m2", bus.HRDATA_M2, 32'h0000_4444);
        chk("cont_hready_m1_w", 32'(bus.HREADY_M1), 0);
        cyc(); #1;
        chk("cont_haddr_m1", bus.HADDR, 32'h0000_3000);
        chk("cont_hready_m1_g", 32'(bus.HREADY_M1), 1);
        cyc(); m1(IDLE, SINGLE, 32'h0); bus.HRDATA = 32'h0000_3333; #1;
        chk("cont_hrdata_m1", bus.HRDATA_M1, 32'h0000_3333);

        // Burst lock: M1 INCR4, M2 asks at beat 2
        cyc(); m1(NONSEQ, INCR4, 32'h0000_0100); #1;
        chk("bl_beat1", bus.HADDR, 32'h0000_0100);
        cyc(); m1(SEQ, INCR4, 32'h0000_0104); m2(NONSEQ, SINGLE, 32'h0000_5000); #1;
        chk("bl_beat2", bus.HADDR, 32'h0000_0104);
        chk("bl_hready_m2_b2", 32'(bus.HREADY_M2), 0);
        cyc(); m1(SEQ, INCR4, 32'h0000_0108); #1;
        chk("bl_beat3", bus.HADDR, 32'h0000_0108);
        cyc(); m1(SEQ, INCR4, 32'h0000_010C); #1;
        chk("bl_beat4", bus.HADDR, 32'h0000_010C);
        chk("bl_hready_m2_b4", 32'(bus.HREADY_M2), 0);
        cyc(); m1(IDLE, SINGLE, 32'h0); #1;
        chk("bl_after_htrans", 32'(bus.HTRANS), 0);
        chk("bl_after_hready_m2", 32'(bus.HREADY_M2), 0);
        cyc(); #1;
        chk("bl_m2_haddr", bus.HADDR, 32'h0000_5000);
        chk("bl_m2_hready", 32'(bus.HREADY_M2), 1);
        cyc(); m2(IDLE, SINGLE, 32'h0); #1;

        // Response capture
        cyc(); m1(NONSEQ, SINGLE, 32'h0000_6000); #1;
        chk("rc_hready_m1_wait", 32'(bus.HREADY_M1), 0);
        cyc(); m2(NONSEQ, SINGLE, 32'h0000_7000); #1;
        chk("rc_m1_haddr", bus.HADDR, 32'h0000_6000);
        chk("rc_m1_hready", 32'(bus.HREADY_M1), 1);
        cyc(); m1(NONSEQ, SINGLE, 32'h0000_6004); bus.HRDATA = 32'h1234_5678; #1;
        chk("rc_m2_haddr", bus.HADDR, 32'h0000_7000);
        chk("rc_hready_m1_dph", 32'(bus.HREADY_M1), 0);
        cyc(); m2(IDLE, SINGLE, 32'h0); bus.HRDATA = 32'hBBBB_0007; #1;
        chk("rc_pend", 32'(dut.pend_reg), 1);
        chk("rc_hready_m1_pend", 32'(bus.HREADY_M1), 0);
        chk("rc_hrdata_m1_hold", bus.HRDATA_M1, 32'h1234_5678);
        chk("rc_hrdata_m2", bus.HRDATA_M2, 32'hBBBB_0007);
        cyc(); bus.HRDATA = 32'h0; #1;
        chk("rc_regrant_hready", 32'(bus.HREADY_M1), 1);
        chk("rc_regrant_hrdata", bus.HRDATA_M1, 32'h1234_5678);
        chk("rc_regrant_haddr", bus.HADDR, 32'h0000_6004);
        cyc(); m1(IDLE, SINGLE, 32'h0); bus.HRDATA = 32'hCAFE_0004; #1;
        chk("rc_new_hrdata", bus.HRDATA_M1, 32'hCAFE_0004);
        chk("rc_pend_clear", 32'(dut.pend_reg), 0);

        // Starvation: both request continuously
        cyc(); m1(NONSEQ, SINGLE, 32'h0000_8000); m2(NONSEQ, SINGLE, 32'h0000_9000); #1;
        chk("st_m1_first", bus.HADDR, 32'h0000_8000);
        for (int k = 1; k <= 16; k++) begin
            cyc(); #1;
            chk($sformatf("st_m2_%0d", k), bus.HADDR, 32'h0000_9000);
        end
        cyc(); #1;
        chk("st_m1_grant", bus.HADDR, 32'h0000_8000);
        chk("st_m1_hready", 32'(bus.HREADY_M1), 1);
        chk("st_streak_full", 32'(dut.streak_reg), 16);
        cyc(); m1(IDLE, SINGLE, 32'hF0F0_0000); #1;
        chk("st_m2_back", bus.HADDR, 32'h0000_9000);
        chk("st_streak_zero", 32'(dut.streak_reg), 0);

        // Async reset during an M2 burst
        cyc(); m2(NONSEQ, INCR4, 32'h0000_A000); #1;
        chk("ar_beat1", bus.HADDR, 32'h0000_A000);
        cyc(); m2(SEQ, INCR4, 32'h0000_A004); #1;
        chk("ar_beat2_htrans", 32'(bus.HTRANS), 3);
        #2; rst = 1'b1; #1;
        chk("ar_a_own", 32'(dut.a_own_reg), 0);
        chk("ar_htrans", 32'(bus.HTRANS), 0);
        chk("ar_haddr", bus.HADDR, 32'hF0F0_0000);
        chk("ar_hready_m2", 32'(bus.HREADY_M2), 0);
        cyc(); rst = 1'b0; m2(IDLE, SINGLE, 32'h0);

        // Two-cycle ERROR response to M2
        cyc(); m2(NONSEQ, SINGLE, 32'h0000_B000); #1;
        chk("er_hready_m2_req", 32'(bus.HREADY_M2), 0);
        cyc(); #1;
        chk("er_haddr", bus.HADDR, 32'h0000_B000);
        chk("er_hready_m2_acc", 32'(bus.HREADY_M2), 1);
        cyc(); m2(IDLE, SINGLE, 32'h0); bus.HREADY = 1'b0; bus.HRESP = 2'b01; #1;
        chk("er_hresp_m2_c1", 32'(bus.HRESP_M2), 1);
        chk("er_hready_m2_c1", 32'(bus.HREADY_M2), 0);
        cyc(); bus.HREADY = 1'b1; #1;
        chk("er_hresp_m2_c2", 32'(bus.HRESP_M2), 1);
        chk("er_hready_m2_c2", 32'(bus.HREADY_M2), 1);
        chk("er_hresp_m1", 32'(bus.HRESP_M1), 0);
        cyc(); #1;
        chk("er_hresp_m2_done", 32'(bus.HRESP_M2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_lite_arbiter.md
# ahb_lite_arbiter

Two-master AHB-Lite arbiter that shares the single system AHB-Lite bus between the RISC-V core (master 1) and the UART debugger (master 2). It is a drop-in replacement for the existing combinational master mux, with identical per-master port names. It adds these functions:
- registered grant with burst locking;
- debugger priority with a core anti-starvation limit;
- response capture, so a master that loses the address phase while its data phase is still open never sees a false transfer acceptance.

## Interface
- STARVE_LIMIT, 16: maximum consecutive accepted M2 transfers while M1 is requesting; after that, M1 gets the next grant.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- HTRANS_M1/M2  in  2  master transfer type.
- HWRITE_M1/M2  in  1  master write strobe.
- HSIZE_M1/M2  in  3  master transfer size.
- HBURST_M1/M2  in  3  master burst type.
- HADDR_M1/M2  in  32  master address.
- HWDATA_M1/M2  in  32  master write data.
- HPROT_M1/M2  in  4  master protection.
- HREADY_M1/M2  out  1  per-master ready.
- HRDATA_M1/M2  out  32  per-master read data.
- HRESP_M1/M2  out  2  per-master response.
- HREADY  in  1  bus ready from slave side.
- HRDATA  in  32  bus read data.
- HRESP  in  2  bus response.
- HTRANS, HWRITE, HSIZE, HBURST, HADDR, HPROT  out  2/1/3/3/32/4  muxed address phase from `a_own`.
- HWDATA  out  32  muxed write data from `d_own`.

## Operation
- State registers:
  - `a_own` (address-phase owner, 0=M1, 1=M2);
  - `d_own` plus `d_act` (data-phase owner, and whether that phase is non-IDLE);
  - `pend1`/`pend2`, with a shared capture register `hold_data[31:0]` and `hold_resp[1:0]`;
  - `streak` counter, $clog2(STARVE_LIMIT+1) bits.
- req_X = HTRANS_MX[1], i.e. NONSEQ or SEQ.
- On every cycle with HREADY=1 (phase advance):
  - `d_own` <= `a_own`; `d_act` <= req of the current `a_own`.
  - Locked: if the owner's HTRANS=SEQ, or it is NONSEQ with HBURST≠SINGLE, `a_own` is held.
  - Otherwise the next `a_own` is chosen in this order:
    - M2, if req_2 and (!req_1 or `streak`<STARVE_LIMIT);
    - else M1, if req_1;
    - else unchanged.
  - `streak`: +1 on each accepted M2 transfer while req_1 is high; cleared when M1 is granted or req_1 is low; saturates at STARVE_LIMIT.
- Per-master HREADY_X:
  - If X = `a_own`: HREADY.
  - Else, if X = `d_own` and `d_act`: HREADY if HTRANS_X=IDLE, else 0.
    - In the second case, when HREADY=1 capture HRDATA/HRESP into hold and set pendX.
  - Else, if pendX: 0.
  - Else: 1 if HTRANS_X=IDLE, 0 if req_X.
- HRDATA_X = pendX ? hold_data : HRDATA.
- HRESP_X:
  - hold_resp if pendX;
  - else HRESP if X = `d_own` and `d_act` (covers both ERROR cycles);
  - else OKAY (2'b00).
- pendX clears on the first cycle where X = `a_own` and HREADY=1. In that cycle X sees both its old data phase complete (hold data) and its held address accepted.
- At most one pend flag is set at a time. A capture never overwrites a live pend.

## Timing
- Reset values:
  - `a_own`=M1, `d_own`=M1, `d_act`=0, pend1=pend2=0, `streak`=0, hold=0.
  - Outputs are therefore M1 pass-through; HWDATA=HWDATA_M1.
  - HREADY_M2=1 while M2 is IDLE.
- Grant latency: a request seen in a cycle with HREADY=1 reaches the bus address phase the next cycle (1 cycle when the bus is free).
- Outputs are combinational muxes of registered selects; there is no data-path latency.
- Reset mid-transfer: all state clears immediately. An open pend is dropped; masters are reset by the same system reset.
- HREADY=0 freezes `a_own`, `d_own`, `streak` and pend.
- Simultaneous first requests from M1 and M2 at `streak`=0: M2 wins.

## Test plan
- **Reset / M1 single read.** Reset, then M1 NONSEQ read 0x0000_1000 with slave HRDATA=0xDEAD_BEEF.
  - HTRANS=2 the same cycle; HRDATA_M1=0xDEAD_BEEF with HREADY_M1=1 one cycle later.
- **Contention.** M1 and M2 both request NONSEQ SINGLE in the same cycle.
  - M2 address on the bus first; HREADY_M1=0 until the cycle after M2 is accepted; M1 address follows.
- **Burst lock.** M1 INCR4 in progress; M2 requests at beat 2.
  - `a_own` stays M1 through all four beats; M2 is granted on the cycle after the 4th beat is accepted.
- **Response capture.** M1 read data phase open (slave returns 0x1234_5678) while `a_own`=M2 and HTRANS_M1=NONSEQ.
  - pend1=1, HREADY_M1=0.
  - When M1 is regranted: HREADY_M1=1 with HRDATA_M1=0x1234_5678 in that cycle.
- **Starvation.** M2 requests continuously; M1 requests continuously.
  - After 16 accepted M2 transfers, M1 gets exactly one grant; `streak` then returns to 0.
- **Async reset mid-burst / ERROR.**
  - Asserting rst during an M2 burst clears `a_own` to M1 with no clock edge.
  - An HRESP=ERROR two-cycle response reaches HRESP_M2 on both cycles.
